// File: rtl/common_types_pkg.sv
// Shared types for the core's memory-side blocks: the 32-bit machine word
// and the AXI response codes, plus a helper that classifies a response.
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  // Full-word write strobe used whenever byte enables are not supplied.
  localparam logic [3:0] WSTRB_ALL = 4'hF;

  // Anything other than OKAY is reported to the requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return axi_resp_t'(resp) != OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding bridge from the core's read/write/ready/done request
// interface to an AXI4-Lite master port. One 32-bit beat per transaction;
// the result is held on the request side until the requester pulses done.
// Optional build macro AXI_CTRL_WSTRB_EN adds a byte_en[3:0] input whose
// latched value drives wstrb; without it wstrb is tied to 4'hF.
module axi_lite_master_bridge
  import common_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store,
`ifdef AXI_CTRL_WSTRB_EN
  input  logic [3:0]        byte_en,
`endif
  input  logic              done,
  output logic              ready,
  output logic [DATA_W-1:0] load,
  output logic              error,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW_W = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic [DATA_W-1:0] r_load;
  logic              r_error;
  logic              r_ready;
  logic              r_aw_done;
  logic              r_w_done;
`ifdef AXI_CTRL_WSTRB_EN
  logic [3:0]        r_wstrb;
`endif

  // Address and write-data channels are each finished once handshaken,
  // either in an earlier cycle or on the coming edge.
  logic w_aw_next;
  logic w_w_next;
  assign w_aw_next = r_aw_done || awready;
  assign w_w_next  = r_w_done  || wready;

  // Transaction sequencer: latch the request, walk the AXI channels, hold the result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_store   <= '0;
      r_load    <= '0;
      r_error   <= 1'b0;
      r_ready   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef AXI_CTRL_WSTRB_EN
      r_wstrb   <= 4'h0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (read || write) begin
            r_addr    <= addr;
            r_store   <= store;
`ifdef AXI_CTRL_WSTRB_EN
            r_wstrb   <= byte_en;
`endif
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            // Read has priority when both requests are raised together.
            r_state   <= read ? S_AR : S_AW_W;
          end
        end
        S_AR: begin
          if (arready) r_state <= S_R;
        end
        S_R: begin
          if (rvalid) begin
            r_load  <= rdata;
            r_error <= resp_is_err(rresp);
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_AW_W: begin
          if (w_aw_next && w_w_next) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_B;
          end else begin
            r_aw_done <= w_aw_next;
            r_w_done  <= w_w_next;
          end
        end
        S_B: begin
          if (bvalid) begin
            r_error <= resp_is_err(bresp);
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (done) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs come straight from registers, so no input-to-output paths exist.
  assign arvalid = (r_state == S_AR);
  assign rready  = (r_state == S_R);
  assign awvalid = (r_state == S_AW_W) && !r_aw_done;
  assign wvalid  = (r_state == S_AW_W) && !r_w_done;
  assign bready  = (r_state == S_B);
  assign araddr  = r_addr;
  assign awaddr  = r_addr;
  assign wdata   = r_store;
`ifdef AXI_CTRL_WSTRB_EN
  assign wstrb   = r_wstrb;
`else
  assign wstrb   = WSTRB_ALL;
`endif
  assign ready   = r_ready;
  assign load    = r_load;
  assign error   = r_error;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge: a requester process, an
// AXI-Lite slave with per-transaction delays and spurious responses, and a
// transaction-level model checked by a monitor every cycle.
module tb_axi_lite_master_bridge;

  logic        clk, nrst, read, write, done;
  logic [31:0] addr, store;
`ifdef AXI_CTRL_WSTRB_EN
  logic [3:0]  byte_en;
`endif
  logic        ready, error;
  logic [31:0] load;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_lite_master_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .nrst(nrst), .read(read), .write(write), .addr(addr),
    .store(store),
`ifdef AXI_CTRL_WSTRB_EN
    .byte_en(byte_en),
`endif
    .done(done), .ready(ready), .load(load), .error(error),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave configuration for the current transaction
  int          ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0;
  bit          junk_en = 1'b0;
  // Cumulative handshake counters kept by the slave
  int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;

  // Transaction model
  bit          cur_active = 1'b0;
  bit          cur_is_read = 1'b0;
  logic [31:0] cur_addr = '0, cur_store = '0;
  logic [3:0]  cur_be = 4'hF;
  logic [31:0] exp_load = '0, model_load = '0;
  logic        exp_err = 1'b0;
  int          b_ar = 0, b_aw = 0, b_w = 0, b_r = 0, b_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // AXI-Lite slave: decides its inputs each falling edge from the bridge's
  // registered outputs; a handshake is counted when it is committed for the
  // next rising edge.
  initial begin
    int  ar_wait, aw_wait, w_wait, r_wait, b_wait;
    bit  r_pend, b_pend, aw_got, w_got;
    ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      end else begin
        // Read data channel
        if (r_pend) begin
          if (r_wait >= r_dly) begin
            rvalid = 1; rdata = s_rdata; rresp = s_rresp;
            if (rready) begin r_hs++; r_pend = 0; end
          end else begin
            rvalid = 0; r_wait++;
          end
        end else if (junk_en) begin
          rvalid = 1'($urandom_range(0, 1)); rdata = $urandom; rresp = 2'($urandom_range(0, 3));
        end else begin
          rvalid = 0;
        end
        // Write response channel
        if (b_pend) begin
          if (b_wait >= b_dly) begin
            bvalid = 1; bresp = s_bresp;
            if (bready) begin b_hs++; b_pend = 0; end
          end else begin
            bvalid = 0; b_wait++;
          end
        end else if (junk_en) begin
          bvalid = 1'($urandom_range(0, 1)); bresp = 2'($urandom_range(0, 3));
        end else begin
          bvalid = 0;
        end
        // Read address channel
        if (arvalid) begin
          if (ar_wait >= ar_dly) begin
            arready = 1; ar_hs++; r_pend = 1; r_wait = 0; ar_wait = 0;
          end else begin
            arready = 0; ar_wait++;
          end
        end else begin
          arready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        // Write address channel
        if (awvalid) begin
          if (aw_wait >= aw_dly) begin
            awready = 1; aw_hs++; aw_got = 1; aw_wait = 0;
          end else begin
            awready = 0; aw_wait++;
          end
        end else begin
          awready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        // Write data channel
        if (wvalid) begin
          if (w_wait >= w_dly) begin
            wready = 1; w_hs++; w_got = 1; w_wait = 0;
          end else begin
            wready = 0; w_wait++;
          end
        end else begin
          wready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (aw_got && w_got) begin
          b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0;
        end
      end
    end
  end

  // Monitor: compares the bridge outputs against the transaction model.
  initial begin
    int ar_c, aw_c, w_c, r_c, b_c;
    forever begin
      @(posedge clk);
      #1;
      if (nrst) begin
        if (!cur_active) begin
          chk("idle_arvalid", arvalid, 0);
          chk("idle_awvalid", awvalid, 0);
          chk("idle_wvalid", wvalid, 0);
          chk("idle_rready", rready, 0);
          chk("idle_bready", bready, 0);
          chk("idle_ready", ready, 0);
        end else begin
          ar_c = ar_hs - b_ar; aw_c = aw_hs - b_aw; w_c = w_hs - b_w;
          r_c = r_hs - b_r; b_c = b_hs - b_b;
          if (cur_is_read) begin
            chk("rd_arvalid", arvalid, ar_c == 0);
            chk("rd_rready", rready, (ar_c == 1) && (r_c == 0));
            chk("rd_ready", ready, r_c == 1);
            chk("rd_no_awvalid", awvalid, 0);
            chk("rd_no_wvalid", wvalid, 0);
            chk("rd_no_bready", bready, 0);
            if (arvalid) chk("araddr", araddr, cur_addr);
          end else begin
            chk("wr_awvalid", awvalid, aw_c == 0);
            chk("wr_wvalid", wvalid, w_c == 0);
            chk("wr_bready", bready, (aw_c == 1) && (w_c == 1) && (b_c == 0));
            chk("wr_ready", ready, b_c == 1);
            chk("wr_no_arvalid", arvalid, 0);
            chk("wr_no_rready", rready, 0);
            if (awvalid) chk("awaddr", awaddr, cur_addr);
            if (wvalid) begin
              chk("wdata", wdata, cur_store);
              chk("wstrb", {28'd0, wstrb}, {28'd0, cur_be});
            end
          end
          if (ready) begin
            chk("load", load, exp_load);
            chk("error", {31'd0, error}, {31'd0, exp_err});
          end
        end
      end
    end
  end

  // Present a request and arm the slave and the model for it.
  task automatic start_txn(input bit do_rd, input bit do_wr, input logic [31:0] a,
                           input logic [31:0] st, input logic [3:0] be,
                           input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br,
                           input int ad, input int wd, input int rdl, input int bd);
    ar_dly = ad; aw_dly = ad; w_dly = wd; r_dly = rdl; b_dly = bd;
    s_rdata = rd; s_rresp = rr; s_bresp = br;
    b_ar = ar_hs; b_aw = aw_hs; b_w = w_hs; b_r = r_hs; b_b = b_hs;
    cur_is_read = do_rd;
    cur_addr = a; cur_store = st;
`ifdef AXI_CTRL_WSTRB_EN
    cur_be = be;
    byte_en = be;
`else
    cur_be = 4'hF;
`endif
    exp_load = do_rd ? rd : model_load;
    exp_err = do_rd ? (rr != 2'b00) : (br != 2'b00);
    cur_active = 1'b1;
    read = do_rd; write = do_wr; addr = a; store = st;
  endtask

  // Full transaction: request, wait for ready, hold, acknowledge.
  task automatic run_txn(input bit do_rd, input bit do_wr, input logic [31:0] a,
                         input logic [31:0] st, input logic [3:0] be,
                         input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br,
                         input int ad, input int wd, input int rdl, input int bd,
                         input int hold, input bit drop_early,
                         output int lat, output logic [31:0] got_load, output logic got_err);
    int exp_lat;
    start_txn(do_rd, do_wr, a, st, be, rd, rr, br, ad, wd, rdl, bd);
    exp_lat = do_rd ? (1 + (ad + 1) + (rdl + 1))
                    : (1 + (((ad > wd) ? ad : wd) + 1) + (bd + 1));
    lat = 0;
    got_load = '0; got_err = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (drop_early && lat == 1) begin read = 0; write = 0; end
      if (ready) break;
      if (lat > 100) begin
        checks++; failures++;
        $display("FAIL ready_timeout actual=%0d required=%0d", lat, exp_lat);
        break;
      end
    end
    chk("latency", lat, exp_lat);
    got_load = load; got_err = error;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    tick();
    done = 1; read = 0; write = 0; cur_active = 1'b0;
    tick();
    done = 0;
    chk("ready_after_done", {31'd0, ready}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n;
    logic [31:0] gl;
    logic        ge;
    bit          rd_op, wr_op;
    int          op;
    nrst = 1; read = 0; write = 0; done = 0; addr = '0; store = '0;
`ifdef AXI_CTRL_WSTRB_EN
    byte_en = 4'hF;
`endif
    #2 nrst = 0;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    @(posedge clk); #2 nrst = 1;
    tick();

    // Zero-wait read of 0x20
    run_txn(1, 0, 32'h20, 32'h0, 4'hF, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, lat, gl, ge);
    chk("t1_latency", lat, 3);
    chk("t1_load", gl, 32'hDEADBEEF);
    chk("t1_error", {31'd0, ge}, 0);
    model_load = 32'hDEADBEEF;

    // Write with awready delayed two cycles, wready immediate
    run_txn(0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00, 2'b00, 2, 0, 0, 0, 0, 0, lat, gl, ge);
    chk("t2_latency", lat, 5);
    chk("t2_error", {31'd0, ge}, 0);
    chk("t2_load_kept", gl, 32'hDEADBEEF);

    // Read returning SLVERR
    run_txn(1, 0, 32'h44, 32'h0, 4'hF, 32'h12345678, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, lat, gl, ge);
    chk("t3_load", gl, 32'h12345678);
    chk("t3_error", {31'd0, ge}, 1);
    model_load = 32'h12345678;

    // Read and write together: only the read channel is used
    run_txn(1, 1, 32'h80, 32'h55AA55AA, 4'hF, 32'hA5A5_0F0F, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, lat, gl, ge);
    chk("t4_load", gl, 32'hA5A50F0F);
    chk("t4_error", {31'd0, ge}, 0);
    model_load = 32'hA5A50F0F;

    // Reset while waiting in R
    start_txn(1, 0, 32'h100, 32'h0, 4'hF, 32'h11112222, 2'b00, 2'b00, 0, 0, 8, 0);
    n = 0;
    while ((ar_hs - b_ar) == 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("t5_ar_done", ar_hs - b_ar, 1);
    #1 chk("t5_in_r", {31'd0, rready}, 1);
    nrst = 0; cur_active = 1'b0; read = 0;
    #1 chk_all_zero("t5_abort");
    repeat (2) @(negedge clk);
    @(posedge clk); #2 nrst = 1;
    model_load = '0;
    tick();

    // Normal read after reset, result held for ten cycles
    run_txn(1, 0, 32'h104, 32'h0, 4'hF, 32'h0BADCAFE, 2'b00, 2'b00, 0, 0, 0, 0, 10, 0, lat, gl, ge);
    chk("t6_latency", lat, 3);
    chk("t6_load", gl, 32'h0BADCAFE);
    chk("t6_held_load", load, 32'h0BADCAFE);
    model_load = 32'h0BADCAFE;

    // Randomized traffic with spurious slave responses
    junk_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      rd_op = (op != 1);
      wr_op = (op != 0);
      run_txn(rd_op, wr_op, {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, 4'($urandom_range(0, 15)),
              $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, gl, ge);
      if (rd_op) model_load = s_rdata;
    end
    junk_en = 1'b0;

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
